multicycle_cpu: RTL and testbench

//  Parametrised multi-cycle successor to the single-cycle core: same 32-bit MIPS-style ISA subset,
//  but one shared memory port with req/ack handshake, so each instruction takes 3-5+ cycles.

---
 rtl/cpu_pkg.sv | 72 +++++++
 rtl/cpu_regfile.sv | 28 ++
 rtl/multicycle_cpu.sv | 185 ++++++++++++++++++
 tb/tb_multicycle_cpu.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle core: FSM states, opcodes, functs,
// ALU operations and the small decode helpers used by the datapath.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } cpu_state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct,
                                      input logic has_jal);
        case (op)
            OP_RTYPE: return funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
            OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI,
            OP_ORI, OP_LW, OP_SW, OP_HALT: return 1'b1;
            OP_JAL:   return has_jal;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic alu_op_e funct_to_alu(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic [31:0] alu_calc(input alu_op_e op, input logic [31:0] a,
                                             input logic [31:0] b);
        case (op)
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_SLT: return {31'd0, $signed(a) < $signed(b)};
            default: return a + b;
        endcase
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port.
// Register 0 reads as zero and ignores writes.
module cpu_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra_i,
    input  logic [4:0]  rb_i,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd_a_o,
    output logic [31:0] rd_b_o
);

    logic [31:0] rf_q [32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_q[0] <= '0;
        end else if (we_i && (wa_i != 5'd0)) begin
            rf_q[wa_i] <= wd_i;
        end
    end

    assign rd_a_o = (ra_i == 5'd0) ? 32'd0 : rf_q[ra_i];
    assign rd_b_o = (rb_i == 5'd0) ? 32'd0 : rf_q[rb_i];

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle MIPS-subset core sharing one req/ack memory port for fetch and data.
// Each instruction walks FETCH/DECODE/EXEC and optionally MEM and WB.
module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MEM_AW   = 16,
    parameter bit          HAS_JAL  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              halted,
    output logic              illegal,
    output logic [31:0]       pc_dbg,
    output cpu_state_e        state_dbg
);

    cpu_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic [31:0] alu_q, alu_d, mdr_q, mdr_d;
    logic        illegal_q, illegal_d;
    logic        gap_q;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic [31:0] sext_imm, zext_imm, br_off, rf_a, rf_b, addr_full;
    logic        ack, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        unused_bits;

    assign op       = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign imm16    = ir_q[15:0];
    assign sext_imm = {{16{imm16[15]}}, imm16};
    assign zext_imm = {16'd0, imm16};
    assign br_off   = {{14{imm16[15]}}, imm16, 2'b00};

    // A one-cycle gap after every ack keeps req low between back-to-back transfers (SW -> FETCH).
    assign mem_req   = (state_q == S_FETCH || state_q == S_MEM) && !gap_q && !rst;
    assign addr_full = (state_q == S_MEM) ? alu_q : pc_q;
    assign mem_addr  = mem_req ? {addr_full[MEM_AW-1:2], 2'b00} : '0;
    assign mem_we    = mem_req && (state_q == S_MEM) && (op == OP_SW);
    assign mem_wdata = mem_we ? b_q : 32'd0;
    assign ack       = mem_ack && mem_req;

    assign halted    = (state_q == S_HALT);
    assign illegal   = illegal_q;
    assign pc_dbg    = pc_q;
    assign state_dbg = state_q;

    assign unused_bits = ^{ir_q[10:6], addr_full[31:MEM_AW], addr_full[1:0]};

    cpu_regfile u_rf (
        .clk    (clk),
        .rst    (rst),
        .ra_i   (rs),
        .rb_i   (rt),
        .we_i   (rf_we),
        .wa_i   (rf_waddr),
        .wd_i   (rf_wdata),
        .rd_a_o (rf_a),
        .rd_b_o (rf_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            illegal_q <= 1'b0;
            gap_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_q     <= alu_d;
            mdr_q     <= mdr_d;
            illegal_q <= illegal_d;
            gap_q     <= ack;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        illegal_d = illegal_q;
        rf_we     = 1'b0;
        rf_waddr  = rt;
        rf_wdata  = alu_q;
        case (state_q)
            S_FETCH: begin
                if (ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rf_a;
                b_d     = rf_b;
                alu_d   = pc_q + br_off;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (!is_legal(op, funct, HAS_JAL)) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    case (op)
                        OP_RTYPE: begin
                            alu_d   = alu_calc(funct_to_alu(funct), a_q, b_q);
                            state_d = S_WB;
                        end
                        OP_ADDI: begin alu_d = a_q + sext_imm; state_d = S_WB; end
                        OP_ANDI: begin alu_d = a_q & zext_imm; state_d = S_WB; end
                        OP_ORI:  begin alu_d = a_q | zext_imm; state_d = S_WB; end
                        OP_LW, OP_SW: begin
                            alu_d   = a_q + sext_imm;
                            state_d = S_MEM;
                        end
                        // alu_q still holds the branch target computed in DECODE
                        OP_BEQ: begin
                            if (a_q == b_q) pc_d = alu_q;
                            state_d = S_FETCH;
                        end
                        OP_BNE: begin
                            if (a_q != b_q) pc_d = alu_q;
                            state_d = S_FETCH;
                        end
                        OP_J: begin
                            pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                            state_d = S_FETCH;
                        end
                        OP_JAL: begin
                            pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                            alu_d   = pc_q;
                            state_d = S_WB;
                        end
                        default: state_d = S_HALT;
                    endcase
                end
            end
            S_MEM: begin
                if (ack) begin
                    if (op == OP_SW) begin
                        state_d = S_FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_waddr = (op == OP_RTYPE) ? rd : ((op == OP_JAL) ? 5'd31 : rt);
                rf_wdata = (op == OP_LW) ? mdr_q : alu_q;
                state_d  = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
    end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: a wait-state memory responder, write scoreboard,
// and hand-computed register, PC and cycle-count expectations.
module tb_multicycle_cpu;
    import cpu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, rst_nj = 1'b1, sel_nj = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    logic m_req, m_we, m_halted, m_illegal;
    logic [15:0] m_addr;
    logic [31:0] m_wdata, m_pc;
    cpu_state_e  m_state;
    logic n_req, n_we, n_halted, n_illegal;
    logic [15:0] n_addr;
    logic [31:0] n_wdata, n_pc;
    cpu_state_e  n_state;

    multicycle_cpu dut (
        .clk(clk), .rst(rst), .mem_req(m_req), .mem_we(m_we), .mem_addr(m_addr),
        .mem_wdata(m_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack & ~sel_nj),
        .halted(m_halted), .illegal(m_illegal), .pc_dbg(m_pc), .state_dbg(m_state)
    );

    multicycle_cpu #(.HAS_JAL(1'b0)) dut_nj (
        .clk(clk), .rst(rst_nj), .mem_req(n_req), .mem_we(n_we), .mem_addr(n_addr),
        .mem_wdata(n_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack & sel_nj),
        .halted(n_halted), .illegal(n_illegal), .pc_dbg(n_pc), .state_dbg(n_state)
    );

    logic        bus_req, bus_we, bus_halted;
    logic [15:0] bus_addr;
    logic [31:0] bus_wdata;
    assign bus_req    = sel_nj ? n_req    : m_req;
    assign bus_we     = sel_nj ? n_we     : m_we;
    assign bus_addr   = sel_nj ? n_addr   : m_addr;
    assign bus_wdata  = sel_nj ? n_wdata  : m_wdata;
    assign bus_halted = sel_nj ? n_halted : m_halted;

    logic [31:0] mem [0:255];
    logic [47:0] exp_q[$];
    logic [47:0] act_q[$];
    logic [15:0] rd_log[$];
    int n_checks = 0, n_errors = 0;
    int wait_n = 0, wait_cnt = 0, stab_err = 0, gap_err = 0, req_cycles = 0;
    logic hold_ack = 1'b0, prev_pending = 1'b0, prev_acked = 1'b0;
    logic [15:0] held_addr;
    logic        held_we;
    logic [31:0] held_wdata;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Memory responder: acks after wait_n stall cycles, logs reads/writes and protocol errors.
    always @(negedge clk) begin
        if (bus_req) begin
            req_cycles++;
            if (prev_pending && (bus_addr != held_addr || bus_we != held_we ||
                                 bus_wdata != held_wdata)) stab_err++;
            if (prev_acked) gap_err++;
            held_addr  = bus_addr;
            held_we    = bus_we;
            held_wdata = bus_wdata;
            if (!hold_ack && wait_cnt >= wait_n) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[bus_addr[9:2]];
                if (bus_we) begin
                    mem[bus_addr[9:2]] = bus_wdata;
                    act_q.push_back({bus_addr, bus_wdata});
                end else begin
                    rd_log.push_back(bus_addr);
                end
                wait_cnt     = 0;
                prev_pending = 1'b0;
                prev_acked   = 1'b1;
            end else begin
                mem_ack      = 1'b0;
                wait_cnt++;
                prev_pending = 1'b1;
                prev_acked   = 1'b0;
            end
        end else begin
            mem_ack      = 1'b0;
            wait_cnt     = 0;
            prev_pending = 1'b0;
            prev_acked   = 1'b0;
        end
    end

    function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                          logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                          logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction
    function automatic logic [31:0] enc_j(logic [5:0] op, logic [31:0] target);
        return {op, target[27:2]};
    endfunction

    task automatic reset_on(input logic nj, input int waits);
        @(posedge clk); #1;
        rst = 1'b1; rst_nj = 1'b1; sel_nj = nj; hold_ack = 1'b0; wait_n = waits;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        exp_q.delete(); act_q.delete(); rd_log.delete();
        stab_err = 0; gap_err = 0; req_cycles = 0;
        @(posedge clk); #1;
    endtask

    task automatic release_rst();
        @(posedge clk); #1;
        if (sel_nj) rst_nj = 1'b0; else rst = 1'b0;
    endtask

    task automatic run_until_halt(input int max_cycles, output int cycles);
        cycles = 0;
        while (bus_halted !== 1'b1 && cycles < max_cycles) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("halt_reached", {31'd0, bus_halted}, 32'd1);
    endtask

    task automatic sb_compare(input string tag);
        check({tag, "_wr_count"}, act_q.size(), exp_q.size());
        while (exp_q.size() > 0 && act_q.size() > 0)
            check({tag, "_wr"}, act_q.pop_front(), exp_q.pop_front());
    endtask

    task automatic load_add_prog();
        mem[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5);
        mem[1] = enc_i(OP_ADDI, 5'd0, 5'd2, 16'd7);
        mem[2] = enc_r(5'd1, 5'd2, 5'd3, FN_ADD);
        mem[3] = {OP_HALT, 26'd0};
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;

        // Reset state and straight-line program, zero-wait memory
        reset_on(1'b0, 0);
        load_add_prog();
        check("rst_req",     {31'd0, m_req}, 32'd0);
        check("rst_we",      {31'd0, m_we}, 32'd0);
        check("rst_addr",    {16'd0, m_addr}, 32'd0);
        check("rst_wdata",   m_wdata, 32'd0);
        check("rst_halted",  {31'd0, m_halted}, 32'd0);
        check("rst_illegal", {31'd0, m_illegal}, 32'd0);
        check("rst_pc",      m_pc, 32'd0);
        check("rst_state",   {29'd0, m_state}, {29'd0, S_FETCH});
        release_rst();
        run_until_halt(200, cyc);
        check("t1_cycles",  cyc, 32'd15);
        check("t1_r1",      dut.u_rf.rf_q[1], 32'd5);
        check("t1_r3",      dut.u_rf.rf_q[3], 32'd12);
        check("t1_illegal", {31'd0, m_illegal}, 32'd0);
        check("t1_fetches", rd_log.size(), 32'd4);
        check("t1_pc",      m_pc, 32'h10);
        sb_compare("t1");

        // Same program, three wait states on every access
        reset_on(1'b0, 3);
        load_add_prog();
        release_rst();
        run_until_halt(200, cyc);
        check("t2_cycles",  cyc, 32'd27);
        check("t2_r3",      dut.u_rf.rf_q[3], 32'd12);
        check("t2_stable",  stab_err, 32'd0);
        check("t2_fetches", rd_log.size(), 32'd4);

        // Store then load through one wait state
        reset_on(1'b0, 1);
        mem[0]  = enc_j(OP_J, 32'h20);
        mem[8]  = enc_i(OP_LW, 5'd0, 5'd3, 16'h80);
        mem[9]  = enc_i(OP_SW, 5'd0, 5'd3, 16'h8);
        mem[10] = enc_i(OP_LW, 5'd0, 5'd4, 16'h8);
        mem[11] = {OP_HALT, 26'd0};
        mem[32] = 32'hDEADBEEF;
        exp_q.push_back({16'h0008, 32'hDEADBEEF});
        release_rst();
        run_until_halt(300, cyc);
        check("t3_r3",     dut.u_rf.rf_q[3], 32'hDEADBEEF);
        check("t3_r4",     dut.u_rf.rf_q[4], 32'hDEADBEEF);
        check("t3_pc",     m_pc, 32'h30);
        check("t3_gap",    gap_err, 32'd0);
        check("t3_stable", stab_err, 32'd0);
        sb_compare("t3");

        // Branch loop at 0x40 after a not-taken bne
        reset_on(1'b0, 0);
        mem[0]  = enc_i(OP_BNE, 5'd0, 5'd0, 16'd5);
        mem[1]  = enc_j(OP_J, 32'h40);
        mem[16] = enc_i(OP_BEQ, 5'd0, 5'd0, 16'hFFFF);
        release_rst();
        repeat (30) @(posedge clk);
        #1;
        check("t4_nfetch", {31'd0, rd_log.size() >= 5}, 32'd1);
        if (rd_log.size() >= 5) begin
            check("t4_f0", {16'd0, rd_log[0]}, 32'h0);
            check("t4_f1", {16'd0, rd_log[1]}, 32'h4);
            check("t4_f2", {16'd0, rd_log[2]}, 32'h40);
            check("t4_f3", {16'd0, rd_log[3]}, 32'h40);
            check("t4_f4", {16'd0, rd_log[4]}, 32'h40);
        end
        cyc = 0;
        while (!m_req && cyc < 5) begin @(posedge clk); #1; cyc++; end
        check("t4_pc_fetch", m_pc, 32'h40);
        check("t4_halted",   {31'd0, m_halted}, 32'd0);

        // JAL legal on the default core
        reset_on(1'b0, 0);
        mem[0]  = enc_j(OP_JAL, 32'h30);
        mem[12] = {OP_HALT, 26'd0};
        release_rst();
        run_until_halt(100, cyc);
        check("jal_r31",     dut.u_rf.rf_q[31], 32'h4);
        check("jal_pc",      m_pc, 32'h34);
        check("jal_illegal", {31'd0, m_illegal}, 32'd0);

        // ALU coverage: slt signed, sub, zero-extended andi/ori, or, and
        reset_on(1'b0, 0);
        mem[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'hFFFD);
        mem[1] = enc_i(OP_ADDI, 5'd0, 5'd2, 16'd2);
        mem[2] = enc_r(5'd1, 5'd2, 5'd5, FN_SLT);
        mem[3] = enc_r(5'd2, 5'd1, 5'd6, FN_SUB);
        mem[4] = enc_i(OP_ORI, 5'd2, 5'd7, 16'h8000);
        mem[5] = enc_i(OP_ANDI, 5'd1, 5'd8, 16'h80F0);
        mem[6] = enc_r(5'd1, 5'd2, 5'd9, FN_OR);
        mem[7] = enc_r(5'd1, 5'd2, 5'd10, FN_AND);
        mem[8] = {OP_HALT, 26'd0};
        release_rst();
        run_until_halt(200, cyc);
        check("alu_slt",  dut.u_rf.rf_q[5], 32'd1);
        check("alu_sub",  dut.u_rf.rf_q[6], 32'd5);
        check("alu_ori",  dut.u_rf.rf_q[7], 32'h0000_8002);
        check("alu_andi", dut.u_rf.rf_q[8], 32'h0000_80F0);
        check("alu_or",   dut.u_rf.rf_q[9], 32'hFFFF_FFFF);
        check("alu_and",  dut.u_rf.rf_q[10], 32'h0);

        // Illegal opcode 0x11 at 0x10
        reset_on(1'b0, 0);
        mem[0] = enc_j(OP_J, 32'h10);
        mem[4] = 32'h4400_0000;
        release_rst();
        run_until_halt(100, cyc);
        check("ill_illegal", {31'd0, m_illegal}, 32'd1);
        check("ill_pc",      m_pc, 32'h14);
        req_cycles = 0;
        repeat (10) @(posedge clk);
        #1;
        check("ill_no_req", req_cycles, 32'd0);

        // JAL on a core built without it traps as illegal
        reset_on(1'b1, 0);
        mem[0]  = enc_j(OP_JAL, 32'h30);
        mem[12] = {OP_HALT, 26'd0};
        release_rst();
        run_until_halt(100, cyc);
        check("nj_illegal", {31'd0, n_illegal}, 32'd1);
        check("nj_pc",      n_pc, 32'h4);

        // Reset while a fetch is pending, then $0 write is discarded
        reset_on(1'b0, 0);
        mem[0] = enc_i(OP_ADDI, 5'd0, 5'd0, 16'd9);
        mem[1] = {OP_HALT, 26'd0};
        hold_ack = 1'b1;
        release_rst();
        repeat (3) @(posedge clk);
        #1;
        check("t6_pending", {31'd0, m_req}, 32'd1);
        rst = 1'b1;
        #1;
        check("t6_req_drop", {31'd0, m_req}, 32'd0);
        check("t6_pc_reset", m_pc, 32'h0);
        rd_log.delete();
        hold_ack = 1'b0;
        release_rst();
        run_until_halt(100, cyc);
        check("t6_nfetch", {31'd0, rd_log.size() >= 1}, 32'd1);
        if (rd_log.size() >= 1) check("t6_first_fetch", {16'd0, rd_log[0]}, 32'h0);
        check("t6_r0",     dut.u_rf.rf_q[0], 32'h0);
        check("t6_cycles", cyc, 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
